// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction fetch stage. Owns the PC, drives the instruction
//               memory address, and queues fetched words toward decode.
// Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misalign_err,
    output logic [31:0] fetch_cnt
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fetch_cnt_q, fetch_cnt_d;
    logic          misalign_q, misalign_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic          pop;
    logic          fire;

    always_comb begin
        id_valid    = (count_q != '0) & ~redirect_valid;
        pop         = id_valid & id_ready;
        fire        = fetch_en & ~redirect_valid & ((count_q < DEPTH_C) | pop);
        id_instr    = id_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
        id_pc       = id_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
        id_pc_plus4 = id_valid ? (pc_mem_q[rd_ptr_q] + 32'd4) : 32'h0;

        pc_d        = pc_q;
        fetch_cnt_d = fetch_cnt_q;
        misalign_d  = misalign_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        // A redirect squashes both the pending pop and the pending push.
        if (redirect_valid) begin
            pc_d       = {redirect_target[31:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            misalign_d = misalign_q | (redirect_target[1:0] != 2'b00);
        end else begin
            if (fire) begin
                pc_d        = pc_q + 32'd4;
                fetch_cnt_d = fetch_cnt_q + 32'd1;
                wr_ptr_d    = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(fire) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= 32'h0;
            misalign_q  <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            misalign_q  <= misalign_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: it is only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (fire) begin
            instr_mem_q[wr_ptr_q] <= im_instr;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

    assign im_addr      = pc_q;
    assign misalign_err = misalign_q;
    assign fetch_cnt    = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit against a queue model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk             = 1'b0;
    logic        rst_n           = 1'b1;
    logic        fetch_en        = 1'b0;
    logic        id_ready        = 1'b0;
    logic        redirect_valid  = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign_err;
    logic [31:0] fetch_cnt;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_pc4;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return 32'h2000_0000 + (a >> 2);
    endfunction

    assign im_instr = im_word(im_addr);

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .im_addr         (im_addr),
        .im_instr        (im_instr),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misalign_err    (misalign_err),
        .fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_pc  = RESET_PC;
        m_cnt = 32'h0;
        m_mis = 1'b0;
    endtask

    // Drive this cycle's inputs, then derive expected outputs at the negedge.
    task automatic cyc_begin(input logic fe, input logic rdy, input logic rv, input logic [31:0] rt);
        fetch_en        = fe;
        id_ready        = rdy;
        redirect_valid  = rv;
        redirect_target = rt;
        @(negedge clk);
        e_valid = (q.size() != 0) && !rv;
        e_instr = e_valid ? q[0].instr : 32'h0;
        e_pc    = e_valid ? q[0].pc : 32'h0;
        e_pc4   = e_valid ? q[0].pc + 32'd4 : 32'h0;
    endtask

    // Apply the model's state change for the upcoming edge, then cross it.
    task automatic cyc_end();
        bit     pop;
        bit     fire;
        entry_t e;
        pop  = e_valid && id_ready;
        fire = fetch_en && !redirect_valid && ((q.size() < DEPTH) || pop);
        if (redirect_valid) begin
            q.delete();
            m_pc  = {redirect_target[31:2], 2'b00};
            m_mis = m_mis | (redirect_target[1:0] != 2'b00);
        end else begin
            if (pop) void'(q.pop_front());
            if (fire) begin
                e.instr = im_word(m_pc);
                e.pc    = m_pc;
                q.push_back(e);
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        fetch_en       = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        fetch_en = 1'b1;
        id_ready = 1'b1;
        model_reset();
        #1;
        n_checks++; if (im_addr !== RESET_PC) $display("FAIL reset_im_addr: got %h exp %h", im_addr, RESET_PC); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b exp 0", id_valid); else n_pass++;
        n_checks++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr: got %h exp 0", id_instr); else n_pass++;
        n_checks++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc: got %h exp 0", id_pc); else n_pass++;
        n_checks++; if (id_pc_plus4 !== 32'h0) $display("FAIL reset_id_pc_plus4: got %h exp 0", id_pc_plus4); else n_pass++;
        n_checks++; if (fetch_cnt !== 32'h0) $display("FAIL reset_fetch_cnt: got %h exp 0", fetch_cnt); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %b exp 0", misalign_err); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 16; i++) begin
            cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++; if (id_valid !== (i != 0)) $display("FAIL stream_valid[%0d]: got %b exp %b", i, id_valid, (i != 0)); else n_pass++;
            n_checks++; if (id_pc !== e_pc) $display("FAIL stream_pc[%0d]: got %h exp %h", i, id_pc, e_pc); else n_pass++;
            n_checks++; if (id_instr !== e_instr) $display("FAIL stream_instr[%0d]: got %h exp %h", i, id_instr, e_instr); else n_pass++;
            n_checks++; if (id_pc_plus4 !== e_pc4) $display("FAIL stream_pc4[%0d]: got %h exp %h", i, id_pc_plus4, e_pc4); else n_pass++;
            n_checks++; if (fetch_cnt !== 32'(i)) $display("FAIL stream_cnt[%0d]: got %h exp %h", i, fetch_cnt, i); else n_pass++;
            cyc_end();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
            n_checks++; if (im_addr !== m_pc) $display("FAIL bp_addr[%0d]: got %h exp %h", i, im_addr, m_pc); else n_pass++;
            n_checks++; if (id_valid !== e_valid) $display("FAIL bp_valid[%0d]: got %b exp %b", i, id_valid, e_valid); else n_pass++;
            n_checks++; if (id_pc !== e_pc) $display("FAIL bp_pc[%0d]: got %h exp %h", i, id_pc, e_pc); else n_pass++;
            cyc_end();
        end
        n_checks++; if (im_addr !== 32'h8) $display("FAIL bp_hold_addr: got %h exp 00000008", im_addr); else n_pass++;
        n_checks++; if (fetch_cnt !== 32'd2) $display("FAIL bp_hold_cnt: got %0d exp 2", fetch_cnt); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++; if (id_valid !== 1'b1) $display("FAIL bp_drain_valid[%0d]: got %b exp 1", i, id_valid); else n_pass++;
            n_checks++; if (id_pc !== 32'(i * 4)) $display("FAIL bp_drain_pc[%0d]: got %h exp %h", i, id_pc, i * 4); else n_pass++;
            n_checks++; if (id_instr !== e_instr) $display("FAIL bp_drain_instr[%0d]: got %h exp %h", i, id_instr, e_instr); else n_pass++;
            cyc_end();
        end
    endtask

    task automatic test_redirect_full();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
            cyc_end();
        end
        cyc_begin(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL redir_cycle_valid: got %b exp 0", id_valid); else n_pass++;
        n_checks++; if (id_pc !== 32'h0) $display("FAIL redir_cycle_pc: got %h exp 0", id_pc); else n_pass++;
        cyc_end();
        cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL redir_n1_valid: got %b exp 0", id_valid); else n_pass++;
        n_checks++; if (im_addr !== 32'h100) $display("FAIL redir_n1_addr: got %h exp 00000100", im_addr); else n_pass++;
        cyc_end();
        for (int i = 0; i < 4; i++) begin
            cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++; if (id_valid !== 1'b1) $display("FAIL redir_head_valid[%0d]: got %b exp 1", i, id_valid); else n_pass++;
            n_checks++; if (id_pc !== 32'h100 + 32'(i * 4)) $display("FAIL redir_head_pc[%0d]: got %h exp %h", i, id_pc, 32'h100 + 32'(i * 4)); else n_pass++;
            n_checks++; if (id_instr !== e_instr) $display("FAIL redir_head_instr[%0d]: got %h exp %h", i, id_instr, e_instr); else n_pass++;
            cyc_end();
        end
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL redir_misalign: got %b exp 0", misalign_err); else n_pass++;
    endtask

    task automatic test_misaligned();
        cyc_begin(1'b1, 1'b1, 1'b1, 32'h0000_0106);
        cyc_end();
        n_checks++; if (im_addr !== 32'h104) $display("FAIL mis_addr: got %h exp 00000104", im_addr); else n_pass++;
        n_checks++; if (misalign_err !== 1'b1) $display("FAIL mis_flag: got %b exp 1", misalign_err); else n_pass++;
        cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
        cyc_end();
        cyc_begin(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        cyc_end();
        for (int i = 0; i < 3; i++) begin
            cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++; if (misalign_err !== 1'b1) $display("FAIL mis_sticky[%0d]: got %b exp 1", i, misalign_err); else n_pass++;
            n_checks++; if (id_pc !== e_pc) $display("FAIL mis_pc[%0d]: got %h exp %h", i, id_pc, e_pc); else n_pass++;
            cyc_end();
        end
    endtask

    task automatic test_wrap();
        cyc_begin(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        cyc_end();
        cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++; if (im_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h exp fffffffc", im_addr); else n_pass++;
        cyc_end();
        cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++; if (im_addr !== 32'h0) $display("FAIL wrap_addr1: got %h exp 00000000", im_addr); else n_pass++;
        n_checks++; if (id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc: got %h exp fffffffc", id_pc); else n_pass++;
        n_checks++; if (id_pc_plus4 !== 32'h0) $display("FAIL wrap_pc4: got %h exp 00000000", id_pc_plus4); else n_pass++;
        cyc_end();
        cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++; if (id_pc !== 32'h0) $display("FAIL wrap_next_pc: got %h exp 00000000", id_pc); else n_pass++;
        cyc_end();
    endtask

    task automatic test_reset_midop();
        cyc_begin(1'b1, 1'b1, 1'b1, 32'h0000_0043);
        cyc_end();
        for (int i = 0; i < 2; i++) begin
            cyc_begin(1'b1, 1'b0, 1'b0, 32'h0);
            cyc_end();
        end
        n_checks++; if (id_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b exp 1", id_valid); else n_pass++;
        n_checks++; if (misalign_err !== 1'b1) $display("FAIL midrst_pre_mis: got %b exp 1", misalign_err); else n_pass++;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL midrst_valid: got %b exp 0", id_valid); else n_pass++;
        n_checks++; if (im_addr !== RESET_PC) $display("FAIL midrst_addr: got %h exp %h", im_addr, RESET_PC); else n_pass++;
        n_checks++; if (fetch_cnt !== 32'h0) $display("FAIL midrst_cnt: got %h exp 0", fetch_cnt); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL midrst_mis: got %b exp 0", misalign_err); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc_begin(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++; if (id_valid !== 1'b0) $display("FAIL midrst_post_valid: got %b exp 0", id_valid); else n_pass++;
        cyc_end();
    endtask

    task automatic test_random();
        logic        fe, rdy, rv;
        logic [31:0] rt;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            fe  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 1) == 1);
            rv  = ($urandom_range(0, 19) == 0);
            rt  = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            cyc_begin(fe, rdy, rv, rt);
            n_checks++; if (id_valid !== e_valid) $display("FAIL rnd_valid[%0d]: got %b exp %b", i, id_valid, e_valid); else n_pass++;
            n_checks++; if (id_instr !== e_instr) $display("FAIL rnd_instr[%0d]: got %h exp %h", i, id_instr, e_instr); else n_pass++;
            n_checks++; if (id_pc !== e_pc) $display("FAIL rnd_pc[%0d]: got %h exp %h", i, id_pc, e_pc); else n_pass++;
            n_checks++; if (id_pc_plus4 !== e_pc4) $display("FAIL rnd_pc4[%0d]: got %h exp %h", i, id_pc_plus4, e_pc4); else n_pass++;
            n_checks++; if (im_addr !== m_pc) $display("FAIL rnd_addr[%0d]: got %h exp %h", i, im_addr, m_pc); else n_pass++;
            n_checks++; if (fetch_cnt !== m_cnt) $display("FAIL rnd_cnt[%0d]: got %h exp %h", i, fetch_cnt, m_cnt); else n_pass++;
            n_checks++; if (misalign_err !== m_mis) $display("FAIL rnd_mis[%0d]: got %b exp %b", i, misalign_err, m_mis); else n_pass++;
            cyc_end();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misaligned();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the single-cycle core datapath.
- Owns the program counter and drives the address of the combinational instruction memory (IM).
- Captures each fetched word with its PC into a small in-order buffer, and presents it to decode through a valid/ready handshake.
- Handles control-flow redirects (branch/jump) by flushing the buffer and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- DEPTH, 2: fetch buffer entries; legal values 2 or 4.

Ports:
- clk  input  1  rising-edge clock, same clock as the core.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  permits new fetches when high.
- im_addr  output  32  byte address to IM; combinationally equal to the PC register.
- im_instr  input  32  instruction word returned combinationally by IM for im_addr.
- id_valid  output  1  buffer head is valid toward decode.
- id_ready  input  1  decode accepts the head this cycle.
- id_instr  output  32  head instruction.
- id_pc  output  32  PC of head instruction.
- id_pc_plus4  output  32  id_pc + 4, mod 2^32.
- redirect_valid  input  1  control-flow redirect request.
- redirect_target  input  32  new PC for the redirect.
- misalign_err  output  1  sticky flag: a redirect target with nonzero bits [1:0] has been seen.
- fetch_cnt  output  32  count of fetches pushed, wraps mod 2^32.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, so im_addr=RESET_PC.
  - Buffer count=0 and read/write pointers=0.
  - id_valid=0; id_instr, id_pc and id_pc_plus4 are 0.
  - misalign_err=0, fetch_cnt=0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- pop = id_valid & id_ready.
- id_valid = (count!=0) & ~redirect_valid.
- When id_valid=0, id_instr, id_pc and id_pc_plus4 are driven to 0.
- fire = fetch_en & ~redirect_valid & ((count<DEPTH) | pop).
  - On fire, at the rising edge: push {im_instr, pc} at the tail, pc <= pc+4 (0xFFFF_FFFC wraps to 0), fetch_cnt++.
  - When fire=0 and there is no redirect, pc holds and im_addr is stable.
- Full buffer (count==DEPTH):
  - Fetch proceeds only if pop happens in the same cycle; push and pop then occur together and count is unchanged.
  - Otherwise pc holds.
- Empty buffer: no pop is possible; a fire in cycle N gives id_valid=1 in cycle N+1 (one-cycle fetch latency).
- Redirect (highest priority, redirect_valid=1 in cycle N):
  - id_valid is forced 0 in cycle N; the head is not consumed even if id_ready=1.
  - No push in cycle N.
  - At the edge: count<=0, pointers reset, pc <= {redirect_target[31:2],2'b00}.
  - misalign_err <= misalign_err | (redirect_target[1:0]!=0).
  - The target word is fetched in cycle N+1 (if fetch_en=1) and presented with id_valid=1 in cycle N+2.
  - Back-to-back redirects: the last one wins.
- fetch_en=0: no pushes; the buffer continues to drain via pop; pc holds.
- The buffer is strictly FIFO. Entries are registered; the head outputs are a registered-storage mux with no combinational path from im_instr to id_instr.
- Combinational paths: only redirect_valid → id_valid/id_* outputs, and id_ready → fire.
- misalign_err clears only on reset.

Test Plan:
- Reset release, RESET_PC=0, fetch_en=1, id_ready=1, IM[i]=0x2000_0000+i:
  - id_valid rises the cycle after reset deassertion.
  - id_pc sequence is 0, 4, 8, …; id_instr tracks the IM contents.
  - id_pc_plus4 = id_pc+4.
  - fetch_cnt increments once per cycle.
- Backpressure, DEPTH=2, id_ready=0 from the start:
  - Exactly 2 pushes occur; im_addr holds at 0x8; count holds at 2.
  - On raising id_ready, entries for PCs 0x0, 0x4, 0x8 appear in order with no drop and no duplicate.
- Redirect while full, redirect_target=0x0000_0100:
  - id_valid=0 in the redirect cycle.
  - Next head has id_pc=0x100, two cycles later.
  - Old entries are never presented; misalign_err stays 0.
- Misaligned redirect to 0x0000_0106:
  - PC loads 0x104 and misalign_err=1, staying 1 after a later aligned redirect until reset.
- Wrap and reset mid-operation:
  - Redirect to 0xFFFF_FFFC: next fetch pc=0x0.
  - Asserting rst_n=0 with 2 entries buffered: id_valid drops immediately, im_addr=RESET_PC, fetch_cnt=0.
